// File: rtl/fft_64p_16b_out_collector.sv
// Captures one 64-word FFT output frame (optionally bit-reversed), tracks the
// |re|+|im| peak bin, then drains the buffer in index order over valid/ready.
module fft_64p_16b_out_collector #(
  parameter int N_POINTS = 64,
  parameter int DATA_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*DATA_W-1:0]   Out_Stream,
  input  logic                  Data_Out,
  input  logic                  Bit_Rev,
  input  logic                  Rd_Ready,
  output logic                  Rd_Valid,
  output logic [2*DATA_W-1:0]   Rd_Data,
  output logic [5:0]            Rd_Index,
  output logic                  Frame_Done,
  output logic [5:0]            Peak_Bin,
  output logic [DATA_W:0]       Peak_Mag,
  output logic [7:0]            Frame_Count,
  output logic                  Frame_Err,
  output logic                  Overrun,
  output logic                  Busy
);
  localparam logic [5:0] LAST = 6'(N_POINTS - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t                state_q;
  logic [5:0]            cnt_q, rd_idx_q, run_bin_q, peak_bin_q;
  logic [DATA_W:0]       run_mag_q, peak_mag_q;
  logic [7:0]            frame_cnt_q;
  logic                  brev_q, rd_valid_q, frame_done_q, frame_err_q, overrun_q;
  logic [2*DATA_W-1:0]   mem_q [N_POINTS];

  logic [DATA_W:0]       cur_mag, nxt_mag;
  logic [5:0]            wr_idx, nxt_bin;
  logic                  wr_en;

  function automatic logic [5:0] bitrev6(input logic [5:0] k);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = k[5-i];
    return r;
  endfunction

  // abs() of -32768 is 32768 in the unsigned 16-bit result, so no saturation
  function automatic logic [DATA_W:0] mag_f(input logic [2*DATA_W-1:0] w);
    logic [DATA_W-1:0] re, im, ar, ai;
    re = w[2*DATA_W-1:DATA_W];
    im = w[DATA_W-1:0];
    ar = re[DATA_W-1] ? (~re + 1'b1) : re;
    ai = im[DATA_W-1] ? (~im + 1'b1) : im;
    return {1'b0, ar} + {1'b0, ai};
  endfunction

  always_comb begin
    cur_mag = mag_f(Out_Stream);
    wr_idx  = (state_q == IDLE) ? 6'd0 : (brev_q ? bitrev6(cnt_q) : cnt_q);
    wr_en   = Data_Out && (state_q != DRAIN);
    // strict compare: ties keep the earlier-arrived sample
    nxt_mag = (cur_mag > run_mag_q) ? cur_mag : run_mag_q;
    nxt_bin = (cur_mag > run_mag_q) ? wr_idx  : run_bin_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= Out_Stream;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rd_idx_q     <= '0;
      run_bin_q    <= '0;
      peak_bin_q   <= '0;
      run_mag_q    <= '0;
      peak_mag_q   <= '0;
      frame_cnt_q  <= '0;
      brev_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: if (Data_Out) begin
          brev_q    <= Bit_Rev;
          cnt_q     <= 6'd1;
          run_mag_q <= cur_mag;
          run_bin_q <= 6'd0;
          state_q   <= CAPTURE;
        end
        CAPTURE: begin
          if (Data_Out) begin
            cnt_q     <= cnt_q + 6'd1;
            run_mag_q <= nxt_mag;
            run_bin_q <= nxt_bin;
            if (cnt_q == LAST) begin
              state_q      <= DRAIN;
              frame_done_q <= 1'b1;
              peak_mag_q   <= nxt_mag;
              peak_bin_q   <= nxt_bin;
              frame_cnt_q  <= frame_cnt_q + 8'd1;
              rd_idx_q     <= '0;
              rd_valid_q   <= 1'b0;
            end
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        DRAIN: begin
          if (Data_Out) overrun_q <= 1'b1;
          // first DRAIN cycle only raises valid, giving one cycle after Frame_Done
          if (!rd_valid_q) begin
            rd_valid_q <= 1'b1;
          end else if (Rd_Ready) begin
            if (rd_idx_q == LAST) begin
              rd_valid_q <= 1'b0;
              state_q    <= IDLE;
            end else begin
              rd_idx_q <= rd_idx_q + 6'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Rd_Valid    = rd_valid_q;
  assign Rd_Data     = rd_valid_q ? mem_q[rd_idx_q] : '0;
  assign Rd_Index    = rd_idx_q;
  assign Frame_Done  = frame_done_q;
  assign Peak_Bin    = peak_bin_q;
  assign Peak_Mag    = peak_mag_q;
  assign Frame_Count = frame_cnt_q;
  assign Frame_Err   = frame_err_q;
  assign Overrun     = overrun_q;
  assign Busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fft_64p_16b_out_collector.sv
// Directed bench for the FFT output collector: capture, peak, drain, errors, reset.
module tb_fft_64p_16b_out_collector;
  logic        clk = 0, rst = 0;
  logic [31:0] Out_Stream = '0;
  logic        Data_Out = 0, Bit_Rev = 0, Rd_Ready = 0;
  logic        Rd_Valid, Frame_Done, Frame_Err, Overrun, Busy;
  logic [31:0] Rd_Data;
  logic [5:0]  Rd_Index, Peak_Bin;
  logic [16:0] Peak_Mag;
  logic [7:0]  Frame_Count;

  fft_64p_16b_out_collector #(.N_POINTS(64), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .Out_Stream(Out_Stream), .Data_Out(Data_Out),
    .Bit_Rev(Bit_Rev), .Rd_Ready(Rd_Ready), .Rd_Valid(Rd_Valid), .Rd_Data(Rd_Data),
    .Rd_Index(Rd_Index), .Frame_Done(Frame_Done), .Peak_Bin(Peak_Bin),
    .Peak_Mag(Peak_Mag), .Frame_Count(Frame_Count), .Frame_Err(Frame_Err),
    .Overrun(Overrun), .Busy(Busy));

  always #5 clk = ~clk;

  int pass_cnt = 0, tot_cnt = 0, fd_cnt = 0;
  logic [31:0] frm [64];
  logic [31:0] exp_buf [64];
  logic [31:0] got [64];
  int hs, stall_err, order_err, first_cyc, last_cyc;

  always @(negedge clk) if (Frame_Done === 1'b1) fd_cnt++;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // drives words 0..n-1 on consecutive cycles; returns #1 after the last sampling edge
  task automatic send_frame(input bit br, input int n);
    Data_Out = 1; Bit_Rev = br;
    for (int i = 0; i < n; i++) begin
      Out_Stream = frm[i];
      step();
    end
    Data_Out = 0; Out_Stream = '0;
  endtask

  // collects handshakes into got[]; rnd toggles Rd_Ready, ovr pulses Data_Out
  task automatic drain(input bit rnd, input bit ovr);
    logic [31:0] pd; logic [5:0] pi; bit prev_stall;
    int cyc;
    hs = 0; stall_err = 0; order_err = 0; first_cyc = -1; last_cyc = -1;
    prev_stall = 0; cyc = 0; pd = '0; pi = '0;
    for (int i = 0; i < 64; i++) got[i] = 32'hxxxxxxxx;
    while (hs < 64 && cyc < 3000) begin
      Rd_Ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      Data_Out = ovr && (cyc % 5 == 2);
      Out_Stream = 32'hDEADBEEF;
      @(negedge clk);
      if (prev_stall && (Rd_Valid !== 1'b1 || Rd_Data !== pd || Rd_Index !== pi)) stall_err++;
      prev_stall = (Rd_Valid === 1'b1) && !Rd_Ready;
      pd = Rd_Data; pi = Rd_Index;
      if (Rd_Valid === 1'b1 && Rd_Ready) begin
        if (Rd_Index !== 6'(hs)) order_err++;
        got[Rd_Index] = Rd_Data;
        if (hs == 0) first_cyc = cyc;
        last_cyc = cyc;
        hs++;
      end
      step();
      cyc++;
    end
    Rd_Ready = 0; Data_Out = 0; Out_Stream = '0;
  endtask

  function automatic int data_errs();
    int e = 0;
    for (int i = 0; i < 64; i++) if (got[i] !== exp_buf[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst = 0; step(); step();
    tot_cnt++; if ({Rd_Valid, Frame_Done, Frame_Err, Overrun, Busy} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {Rd_Valid, Frame_Done, Frame_Err, Overrun, Busy}); else pass_cnt++;
    tot_cnt++; if ({Rd_Data, Rd_Index, Peak_Bin, Peak_Mag, Frame_Count} !== '0)
      $display("FAIL reset_values: data=%h idx=%0d bin=%0d mag=%0d cnt=%0d want all 0", Rd_Data, Rd_Index, Peak_Bin, Peak_Mag, Frame_Count); else pass_cnt++;
    rst = 1; step();
  endtask

  task automatic test_const_frame();
    for (int i = 0; i < 64; i++) begin frm[i] = 32'h00290000; exp_buf[i] = 32'h00290000; end
    send_frame(0, 64);
    tot_cnt++; if (Frame_Done !== 1'b1) $display("FAIL const_done: got %b want 1", Frame_Done); else pass_cnt++;
    tot_cnt++; if (Peak_Mag !== 17'd41) $display("FAIL const_mag: got %0d want 41", Peak_Mag); else pass_cnt++;
    tot_cnt++; if (Peak_Bin !== 6'd0) $display("FAIL const_bin: got %0d want 0", Peak_Bin); else pass_cnt++;
    tot_cnt++; if (Frame_Count !== 8'd1) $display("FAIL const_count: got %0d want 1", Frame_Count); else pass_cnt++;
    tot_cnt++; if ({Busy, Rd_Valid} !== 2'b10) $display("FAIL const_e0_busy_valid: got %b want 10", {Busy, Rd_Valid}); else pass_cnt++;
    step();
    tot_cnt++; if ({Frame_Done, Rd_Valid, Rd_Index} !== {1'b0, 1'b1, 6'd0})
      $display("FAIL const_e1: done=%b valid=%b idx=%0d want 0,1,0", Frame_Done, Rd_Valid, Rd_Index); else pass_cnt++;
    drain(0, 0);
    tot_cnt++; if (hs !== 64 || order_err !== 0) $display("FAIL const_hs: hs=%0d order_err=%0d want 64,0", hs, order_err); else pass_cnt++;
    tot_cnt++; if (first_cyc !== 0 || last_cyc !== 63) $display("FAIL const_throughput: first=%0d last=%0d want 0,63", first_cyc, last_cyc); else pass_cnt++;
    tot_cnt++; if (data_errs() !== 0) $display("FAIL const_data: errors=%0d want 0", data_errs()); else pass_cnt++;
    tot_cnt++; if ({Busy, Rd_Valid} !== 2'b00) $display("FAIL const_busy_fall: got %b want 00", {Busy, Rd_Valid}); else pass_cnt++;
    tot_cnt++; if (fd_cnt !== 1) $display("FAIL const_done_pulses: got %0d want 1", fd_cnt); else pass_cnt++;
  endtask

  task automatic test_single_peak();
    for (int i = 0; i < 64; i++) begin frm[i] = '0; exp_buf[i] = '0; end
    frm[5] = 32'h80000001; exp_buf[40] = 32'h80000001;
    send_frame(1, 64);
    tot_cnt++; if (Peak_Mag !== 17'd32769) $display("FAIL peak_mag: got %0d want 32769", Peak_Mag); else pass_cnt++;
    tot_cnt++; if (Peak_Bin !== 6'd40) $display("FAIL peak_bin: got %0d want 40", Peak_Bin); else pass_cnt++;
    tot_cnt++; if (Frame_Count !== 8'd2) $display("FAIL peak_count: got %0d want 2", Frame_Count); else pass_cnt++;
    drain(0, 0);
    tot_cnt++; if (hs !== 64 || data_errs() !== 0) $display("FAIL peak_data: hs=%0d errors=%0d want 64,0", hs, data_errs()); else pass_cnt++;
  endtask

  task automatic test_short_frame();
    int fd0;
    fd0 = fd_cnt;
    for (int i = 0; i < 64; i++) begin frm[i] = {16'(i), 16'(i)}; exp_buf[i] = {16'(i), 16'(i)}; end
    send_frame(0, 30);
    step();
    tot_cnt++; if ({Frame_Err, Busy} !== 2'b10) $display("FAIL short_err_busy: got %b want 10", {Frame_Err, Busy}); else pass_cnt++;
    tot_cnt++; if (Frame_Count !== 8'd2 || fd_cnt !== fd0) $display("FAIL short_count: cnt=%0d pulses=%0d want 2,%0d", Frame_Count, fd_cnt, fd0); else pass_cnt++;
    tot_cnt++; if (Peak_Mag !== 17'd32769 || Peak_Bin !== 6'd40) $display("FAIL short_peak_kept: mag=%0d bin=%0d want 32769,40", Peak_Mag, Peak_Bin); else pass_cnt++;
    send_frame(0, 64);
    tot_cnt++; if (Peak_Mag !== 17'd126 || Peak_Bin !== 6'd63) $display("FAIL short_next_peak: mag=%0d bin=%0d want 126,63", Peak_Mag, Peak_Bin); else pass_cnt++;
    tot_cnt++; if (Frame_Count !== 8'd3 || Frame_Err !== 1'b1) $display("FAIL short_next_count: cnt=%0d err=%b want 3,1", Frame_Count, Frame_Err); else pass_cnt++;
    drain(0, 0);
    tot_cnt++; if (hs !== 64 || data_errs() !== 0) $display("FAIL short_next_data: hs=%0d errors=%0d want 64,0", hs, data_errs()); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    // |−k| + (k+100) peaks at k=63: 226
    for (int i = 0; i < 64; i++) begin frm[i] = {16'(-i), 16'(i + 100)}; exp_buf[i] = frm[i]; end
    send_frame(0, 64);
    tot_cnt++; if (Peak_Mag !== 17'd226 || Peak_Bin !== 6'd63) $display("FAIL bp_peak: mag=%0d bin=%0d want 226,63", Peak_Mag, Peak_Bin); else pass_cnt++;
    drain(1, 0);
    tot_cnt++; if (hs !== 64 || order_err !== 0) $display("FAIL bp_hs: hs=%0d order_err=%0d want 64,0", hs, order_err); else pass_cnt++;
    tot_cnt++; if (stall_err !== 0) $display("FAIL bp_stall_stable: got %0d unstable stalls want 0", stall_err); else pass_cnt++;
    tot_cnt++; if (data_errs() !== 0) $display("FAIL bp_data: errors=%0d want 0", data_errs()); else pass_cnt++;
    tot_cnt++; if (Frame_Count !== 8'd4 || Busy !== 1'b0) $display("FAIL bp_count: cnt=%0d busy=%b want 4,0", Frame_Count, Busy); else pass_cnt++;
  endtask

  task automatic test_overrun();
    // samples 10 and 20 tie at 65536; bit-reversed they land at 20 and 10
    for (int i = 0; i < 64; i++) begin frm[i] = 32'h00000001; exp_buf[i] = 32'h00000001; end
    frm[10] = 32'h80008000; frm[20] = 32'h80008000;
    exp_buf[20] = 32'h80008000; exp_buf[10] = 32'h80008000;
    send_frame(1, 64);
    tot_cnt++; if (Peak_Mag !== 17'd65536 || Peak_Bin !== 6'd20) $display("FAIL ovr_peak_tie: mag=%0d bin=%0d want 65536,20", Peak_Mag, Peak_Bin); else pass_cnt++;
    tot_cnt++; if (Overrun !== 1'b0) $display("FAIL ovr_before: got %b want 0", Overrun); else pass_cnt++;
    drain(0, 1);
    tot_cnt++; if (Overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", Overrun); else pass_cnt++;
    tot_cnt++; if (hs !== 64 || data_errs() !== 0) $display("FAIL ovr_data: hs=%0d errors=%0d want 64,0", hs, data_errs()); else pass_cnt++;
    tot_cnt++; if (Frame_Count !== 8'd5 || Busy !== 1'b0) $display("FAIL ovr_count: cnt=%0d busy=%b want 5,0", Frame_Count, Busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // starts on the very cycle after the previous final handshake
    for (int i = 0; i < 64; i++) begin frm[i] = 32'hFFFF0000; exp_buf[i] = 32'hFFFF0000; end
    send_frame(0, 64);
    tot_cnt++; if (Frame_Count !== 8'd6 || Peak_Mag !== 17'd1 || Peak_Bin !== 6'd0)
      $display("FAIL b2b_frame: cnt=%0d mag=%0d bin=%0d want 6,1,0", Frame_Count, Peak_Mag, Peak_Bin); else pass_cnt++;
    drain(0, 0);
    tot_cnt++; if (hs !== 64 || data_errs() !== 0 || Overrun !== 1'b1) $display("FAIL b2b_data: hs=%0d errors=%0d ovr=%b want 64,0,1", hs, data_errs(), Overrun); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 64; i++) begin frm[i] = 32'h00050003; exp_buf[i] = 32'h00050003; end
    send_frame(0, 20);
    rst = 0; Data_Out = 1; Out_Stream = frm[20];
    step();
    rst = 1; Data_Out = 0;
    tot_cnt++; if ({Rd_Valid, Frame_Done, Frame_Err, Overrun, Busy} !== 5'b0)
      $display("FAIL rstmid_flags: got %b want 00000", {Rd_Valid, Frame_Done, Frame_Err, Overrun, Busy}); else pass_cnt++;
    tot_cnt++; if ({Rd_Data, Rd_Index, Peak_Bin, Peak_Mag, Frame_Count} !== '0)
      $display("FAIL rstmid_values: data=%h idx=%0d bin=%0d mag=%0d cnt=%0d want all 0", Rd_Data, Rd_Index, Peak_Bin, Peak_Mag, Frame_Count); else pass_cnt++;
    step();
    send_frame(0, 64);
    tot_cnt++; if (Frame_Count !== 8'd1 || Peak_Mag !== 17'd8) $display("FAIL rstmid_next: cnt=%0d mag=%0d want 1,8", Frame_Count, Peak_Mag); else pass_cnt++;
    drain(0, 0);
    tot_cnt++; if (hs !== 64 || data_errs() !== 0) $display("FAIL rstmid_data: hs=%0d errors=%0d want 64,0", hs, data_errs()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_const_frame();
    test_single_peak();
    test_short_frame();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/fft_64p_16b_out_collector.md
# fft_64p_16b_out_collector

Receive-side companion of the 64-point, 16-bit FFT top. Captures one 64-word output frame from the FFT's `Out_Stream`/`Data_Out` interface into an internal 64×32 buffer. It optionally undoes bit-reversed output ordering and tracks the peak-magnitude bin. It then drains the frame in index order over a valid/ready read port. It sits between `fft_64p_16b_top` and any downstream consumer (host bridge, bench scoreboard).

## Interface
- `N_POINTS`, 64: frame length. Fixed; index width is 6.
- `DATA_W`, 16: width of each real/imag component.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `Out_Stream`  in  32  FFT output word. `[31:16]` is real, `[15:0]` is imag, both two's complement.
- `Data_Out`  in  1  FFT output strobe; high for each valid word.
- `Bit_Rev`  in  1  when 1, sample k is stored at index bitrev6(k). Sampled on the first word of a frame and held for that frame.
- `Rd_Ready`  in  1  consumer accepts `Rd_Data`.
- `Rd_Valid`  out  1  `Rd_Data`/`Rd_Index` are valid.
- `Rd_Data`  out  32  buffered word.
- `Rd_Index`  out  6  bin index of `Rd_Data`.
- `Frame_Done`  out  1  one-cycle pulse when a full frame has been captured.
- `Peak_Bin`  out  6  stored index of the largest-magnitude word of the last good frame.
- `Peak_Mag`  out  17  |re|+|im| of that word, unsigned.
- `Frame_Count`  out  8  count of good frames; wraps 255→0.
- `Frame_Err`  out  1  sticky; set when a short frame occurs.
- `Overrun`  out  1  sticky; set when `Data_Out` arrives during DRAIN.
- `Busy`  out  1  high in CAPTURE or DRAIN.

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - On `Data_Out`=1, write word 0 to its index, latch `Bit_Rev`, set cnt=1, clear the running peak, go to CAPTURE.
  - `Data_Out`=0: remain in IDLE.
- CAPTURE:
  - `Data_Out`=1: write word cnt to its index and increment cnt.
  - After word 63 is written, go to DRAIN. `Frame_Done` pulses, `Peak_Bin`/`Peak_Mag` update, and `Frame_Count` increments.
  - `Data_Out`=0 with cnt<64: set `Frame_Err`, discard the partial frame, go to IDLE. `Peak_*` and `Frame_Count` are unchanged.
- DRAIN:
  - Present indices 0..63 in order with `Rd_Valid`=1.
  - Advance one index per cycle in which `Rd_Valid`&`Rd_Ready`=1.
  - After index 63 is accepted, `Rd_Valid`=0 and state goes to IDLE.
  - `Data_Out`=1 in DRAIN sets `Overrun`; the word is dropped and the buffer is untouched.
- Magnitude:
  - abs of each 16-bit component as unsigned 16-bit (−32768→32768); the sum is 17-bit, with no saturation.
  - The running peak updates only when strictly greater, so a tie keeps the earlier-arrived sample.
  - `Peak_Bin` is the stored (post-reversal) index.
- `Frame_Err` and `Overrun` clear only on reset.

## Timing
- Reset (`rst`=0 at an edge): state=IDLE and every output is 0, including `Peak_*`, `Frame_Count` and the sticky flags.
- Reset mid-CAPTURE or mid-DRAIN aborts immediately. Buffer contents are don't-care.
- Capture accepts one word per cycle with no gaps allowed.
- Let E0 be the edge that samples word 63:
  - After E0: `Frame_Done`=1 for exactly one cycle, `Peak_*` valid, `Busy`=1.
  - After E0+1: `Rd_Valid`=1, `Rd_Index`=0.
- `Rd_Data`/`Rd_Index` are held stable while `Rd_Valid`=1 and `Rd_Ready`=0.
- With `Rd_Ready` held high, throughput is one word per cycle: 64 consecutive handshakes.
- `Busy` falls the cycle after the index-63 handshake. A `Data_Out` on that next cycle starts a new frame normally.
- `Data_Out` coinciding with the final handshake edge counts as overrun.

## Test plan
- Constant frame, `Bit_Rev`=0:
  - Stimulus: 64× `0x00290000`.
  - Response: one `Frame_Done`, `Peak_Mag`=41, `Peak_Bin`=0 (tie rule), `Frame_Count`=1.
  - With `Rd_Ready`=1, 64 words of `0x00290000` at indices 0..63 on consecutive cycles.
- Single peak, `Bit_Rev`=1:
  - Stimulus: sample 5 = `0x80000001`, all other samples 0.
  - Response: `Peak_Mag`=32769, `Peak_Bin`=40; drained index 40 = `0x80000001`, all others 0.
- Short frame:
  - Stimulus: `Data_Out` drops after 30 words.
  - Response: `Frame_Err`=1, no `Frame_Done`, `Busy`=0, `Frame_Count` unchanged.
  - The following full frame captures and drains correctly.
- Backpressure:
  - Stimulus: `Rd_Ready` toggling pseudo-randomly.
  - Response: `Rd_Data` stable while stalled, exactly 64 handshakes, indices strictly 0..63.
- Overrun:
  - Stimulus: `Data_Out` pulses during DRAIN.
  - Response: `Overrun`=1; drained words equal the originally captured frame.
- Reset:
  - Stimulus: `rst`=0 for one cycle at word 20 of a frame.
  - Response: all outputs 0 next cycle; the next full frame gives `Frame_Count`=1.
